huff_canon_ctrl: RTL and testbench
==================================

# huff_canon_ctrl

Sequencer for the Huffman encoder's per-symbol code-length store. It owns a single-port length register array with write-first semantics. It clears the array, loads code lengths from an upstream tree builder, and computes canonical base codes from the length histogram. It then sweeps the array to stream one (symbol, length, code) triple per used symbol to the code-table writer.

## Interface
- LEN_WIDTH, 6, width of a stored code length.
- SYM_NUM, 256, number of symbols (array depth); power of two, SYM_W = $clog2(SYM_NUM).
- MAX_LEN, 16, largest legal code length; code width = MAX_LEN.
- clk  in  1  clock; one clock domain, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
- in_valid / in_ready  in / out  1 / 1  length-load handshake.
- in_sym  in  SYM_W  symbol index of the load beat.
- in_len  in  LEN_WIDTH  code length of the load beat (0 = unused symbol).
- in_last  in  1  marks the final load beat.
- out_valid / out_ready  out / in  1 / 1  code-stream handshake.
- out_sym  out  SYM_W  symbol of the output beat.
- out_len  out  LEN_WIDTH  its code length.
- out_code  out  MAX_LEN  canonical code, right-aligned (LSBs hold the code).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky error; cleared by start or rst.

## Operation
- States: IDLE, CLEAR, LOAD, BASE, ASSIGN, FLUSH.
- IDLE → CLEAR on start. In the same edge: err←0, bl_count[0..MAX_LEN]←0, sweep index←0.
- CLEAR: write 0 to array[idx], one entry per cycle, SYM_NUM cycles → LOAD.
- LOAD: in_ready=1. An accepted beat (in_valid&in_ready) does the following:
  - Reads old=array[in_sym] combinationally.
  - Writes array[in_sym]←in_len.
  - bl_count[old]−− if old≠0; bl_count[in_len]++ if in_len≠0. This makes rewriting a symbol a replace, not a double count.
- Load error case: if in_len>MAX_LEN, err←1 and the array stores 0 with no histogram update.
- in_last on an accepted beat → BASE.
- BASE: runs one length per cycle, l=1..MAX_LEN, with c0=0.
  - code←(code+bl_count[l−1])<<1, where bl_count[0] is treated as 0.
  - next_code[l]←code.
  - Kraft check: if next_code[l]+bl_count[l] > 2^l, err←1.
  - Arithmetic width is MAX_LEN+1 bits.
  - After l=MAX_LEN: → ASSIGN if err=0, else → FLUSH.
- ASSIGN: sweep idx 0..SYM_NUM−1, reading L=array[idx].
  - L=0: skip, 1 cycle.
  - L≠0: load the output register with (idx, L, next_code[L]) and do next_code[L]++.
  - The sweep advances only when the output register is empty or drains in the same cycle (out_valid&out_ready).
  - After idx=SYM_NUM−1 has been consumed, go to FLUSH.
- FLUSH: wait until out_valid=0, then pulse done → IDLE.
- The array port is time-shared: CLEAR, LOAD and ASSIGN each own it exclusively; there is no external access.
- All symbols zero: no output beats, err=0, done pulses.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sym/out_len/out_code=0, busy=0, done=0, err=0. State resets to IDLE; bl_count, next_code and idx reset to 0; array contents are unspecified.
- start outside IDLE is ignored. start while in_valid is high loads nothing until LOAD.
- busy rises the cycle after start. CLEAR takes exactly SYM_NUM cycles, and in_ready rises on the first LOAD cycle.
- BASE takes exactly MAX_LEN cycles.
- ASSIGN takes SYM_NUM cycles plus stall cycles.
- out_valid rises the cycle after the symbol is read. With out_ready held high, it sustains one beat per cycle.
- Output fields are stable while out_valid&!out_ready. No beat is dropped or duplicated.
- done is high for exactly one cycle. busy falls in the cycle after done.
- err is visible at the latest on the cycle after the offending LOAD beat or BASE step, and it holds through done.
- rst mid-job: outputs return to reset values immediately. The next start re-clears the array, so no stale lengths leak into the next job.

## Test plan
- Load sym 65=1, 66=2, 67=3, 68=3, then in_last → beats (65,1,0b0), (66,2,0b10), (67,3,0b110), (68,3,0b111) in order, then done, err=0.
- Load syms 0, 1, 2 with length 1 → err=1 after BASE, no out_valid, one done pulse.
- Load sym 9 with in_len=MAX_LEN+1, plus sym 10=1 → err=1, no output beats, done.
- Load sym 5=3, sym 5=1 (rewrite), sym 6=1 → beats (5,1,0), (6,1,1), err=0.
- Random 40-symbol valid length set with out_ready toggled pseudo-randomly → the decoded prefix-free table matches the model, and the fields are stable during every stall.
- Assert rst mid-ASSIGN, then run scenario 1 again after reset → identical beats to scenario 1, with no beats for symbols from the aborted job.

Source files
------------

// File: rtl/huff_canon_ctrl.sv
// Canonical Huffman code sequencer: clears and loads a per-symbol length array,
// builds base codes from the length histogram, then streams (sym, len, code).
module huff_canon_ctrl #(
    parameter int LEN_WIDTH = 6,
    parameter int SYM_NUM   = 256,
    parameter int MAX_LEN   = 16,
    localparam int SYM_W    = $clog2(SYM_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SYM_W-1:0]     in_sym,
    input  logic [LEN_WIDTH-1:0] in_len,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SYM_W-1:0]     out_sym,
    output logic [LEN_WIDTH-1:0] out_len,
    output logic [MAX_LEN-1:0]   out_code,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = SYM_W + 1;
    localparam int NW = MAX_LEN + 1;
    localparam logic [LEN_WIDTH-1:0] MAXL = LEN_WIDTH'(MAX_LEN);
    localparam logic [SYM_W-1:0]     LAST = SYM_W'(SYM_NUM - 1);
    localparam logic [LW-1:0]        LTOP = LW'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, BASE, ASSIGN, FLUSH} state_t;
    state_t state, state_n;

    logic [LEN_WIDTH-1:0] mem [0:SYM_NUM-1];
    logic [CW-1:0]        bl_count [0:MAX_LEN];
    logic [NW-1:0]        next_code [0:MAX_LEN];
    logic [SYM_W-1:0]     idx, addr;
    logic [LW-1:0]        lidx, old_l, new_l;
    logic [NW-1:0]        code, code_n, prev_cnt;
    logic [LEN_WIDTH-1:0] rd, wdata;
    logic                 acc, bad_len, old_ok, we, kraft_fail, adv, emit;

    // Single array port: LOAD addresses by the incoming symbol, CLEAR/ASSIGN by the sweep index
    assign addr    = (state == LOAD) ? in_sym : idx;
    assign rd      = mem[addr];
    assign acc     = (state == LOAD) && in_valid;
    assign bad_len = in_len > MAXL;
    assign old_ok  = (rd != '0) && (rd <= MAXL);
    assign old_l   = rd[LW-1:0];
    assign new_l   = in_len[LW-1:0];
    assign we      = (state == CLEAR) || acc;
    assign wdata   = ((state == CLEAR) || bad_len) ? '0 : in_len;

    assign prev_cnt   = (lidx == LW'(1)) ? '0 : NW'(bl_count[lidx - LW'(1)]);
    assign code_n     = (code + prev_cnt) << 1;
    assign kraft_fail = ((NW+1)'(code_n) + (NW+1)'(bl_count[lidx])) > ((NW+1)'(1) << lidx);

    assign adv  = (state == ASSIGN) && (!out_valid || out_ready);
    assign emit = adv && old_ok;

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == FLUSH) && !out_valid;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (start) state_n = CLEAR;
            CLEAR:  if (idx == LAST) state_n = LOAD;
            LOAD:   if (acc && in_last) state_n = BASE;
            BASE:   if (lidx == LTOP) state_n = (err || kraft_fail) ? FLUSH : ASSIGN;
            ASSIGN: if (adv && idx == LAST) state_n = FLUSH;
            FLUSH:  if (!out_valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            lidx      <= '0;
            code      <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_len   <= '0;
            out_code  <= '0;
            for (int l = 0; l <= MAX_LEN; l++) begin
                bl_count[l]  <= '0;
                next_code[l] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    err  <= 1'b0;
                    idx  <= '0;
                    lidx <= LW'(1);
                    code <= '0;
                    for (int l = 0; l <= MAX_LEN; l++) bl_count[l] <= '0;
                end
                CLEAR: idx <= idx + 1'b1;
                LOAD: if (acc) begin
                    if (bad_len) err <= 1'b1;
                    else begin
                        // Rewriting a symbol moves its count rather than adding a second one
                        for (int l = 1; l <= MAX_LEN; l++)
                            bl_count[l] <= bl_count[l]
                                - {{(CW-1){1'b0}}, (old_ok && old_l == LW'(l))}
                                + {{(CW-1){1'b0}}, (in_len != '0 && new_l == LW'(l))};
                    end
                end
                BASE: begin
                    next_code[lidx] <= code_n;
                    code            <= code_n;
                    lidx            <= lidx + 1'b1;
                    if (kraft_fail) err <= 1'b1;
                end
                ASSIGN: if (adv) begin
                    idx       <= idx + 1'b1;
                    out_valid <= emit;
                    if (emit) begin
                        out_sym          <= idx;
                        out_len          <= rd;
                        out_code         <= next_code[old_l][MAX_LEN-1:0];
                        next_code[old_l] <= next_code[old_l] + 1'b1;
                    end
                end
                FLUSH: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_canon_ctrl.sv
// Scoreboard bench for huff_canon_ctrl: directed jobs push expected beats,
// a negedge monitor pops and compares each accepted output beat.
module tb_huff_canon_ctrl;
    localparam int SW = 8, LWD = 6, ML = 16, SN = 256;

    logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic           in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [SW-1:0]  in_sym = '0;
    logic [LWD-1:0] in_len = '0;
    logic           in_ready, out_valid, busy, done, err;
    logic [SW-1:0]  out_sym;
    logic [LWD-1:0] out_len;
    logic [ML-1:0]  out_code;

    int          checks = 0, failures = 0;
    logic [29:0] expq[$];
    logic        rand_rdy = 1'b0;
    logic        hold = 1'b0;
    logic [29:0] held = '0;

    huff_canon_ctrl #(.LEN_WIDTH(LWD), .SYM_NUM(SN), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .in_len(in_len), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_len(out_len), .out_code(out_code),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input int s, input int l, input int c);
        expq.push_back({SW'(s), LWD'(l), ML'(c)});
    endtask

    // Monitor: beats are accepted at the next rising edge when valid&ready at negedge
    initial forever begin
        logic [29:0] cur, e;
        @(negedge clk);
        if (rst) hold = 1'b0;
        else begin
            cur = {out_sym, out_len, out_code};
            if (hold) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                if (out_valid) chk("stall_stable", {2'b0, cur}, {2'b0, held});
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", cur);
                end else begin
                    e = expq.pop_front();
                    chk("beat", {2'b0, cur}, {2'b0, e});
                end
            end
            hold = out_valid && !out_ready;
            if (hold) held = cur;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic start_job;
        int n;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_rise", {31'b0, busy}, 32'd1);
        n = 0;
        while (!in_ready && n < SN + 20) begin
            tick;
            n++;
        end
        chk("clear_cycles", n, SN);
    endtask

    task automatic load(input int s, input int l, input bit last);
        in_sym   = SW'(s);
        in_len   = LWD'(l);
        in_valid = 1'b1;
        in_last  = last;
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_job(input bit exp_err);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick;
            n++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        chk("err_at_done", {31'b0, err}, {31'b0, exp_err});
        chk("queue_empty", expq.size(), 0);
        tick;
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("busy_fall", {31'b0, busy}, 32'd0);
        chk("err_hold", {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic scen1;
        exp_beat(65, 1, 0);
        exp_beat(66, 2, 2);
        exp_beat(67, 3, 6);
        exp_beat(68, 3, 7);
        start_job;
        load(65, 1, 0);
        load(66, 2, 0);
        load(67, 3, 0);
        load(68, 3, 1);
        finish_job(0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'b0, in_ready},  32'd0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_fields"}, {2'b0, out_sym, out_len, out_code}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"},  {31'b0, err},  32'd0);
    endtask

    initial begin
        int lens[SN];
        int codes[SN];
        int code, n, s;

        repeat (3) tick;
        check_idle_outputs("reset");
        rst = 1'b0;
        tick;

        // Scenario 1: mixed lengths 1,2,3,3
        scen1;

        // Scenario 2: three length-1 symbols oversubscribe the code space
        start_job;
        load(0, 1, 0);
        load(1, 1, 0);
        load(2, 1, 1);
        finish_job(1);

        // Scenario 3: over-long length flags err immediately
        start_job;
        load(9, ML + 1, 0);
        chk("err_bad_len", {31'b0, err}, 32'd1);
        load(10, 1, 1);
        finish_job(1);

        // Scenario 4: rewrite replaces, it does not double count
        exp_beat(5, 1, 0);
        exp_beat(6, 1, 1);
        start_job;
        load(5, 3, 0);
        load(5, 1, 0);
        load(6, 1, 1);
        finish_job(0);

        // Scenario 5: 40 scattered symbols, random backpressure, canonical model
        for (int i = 0; i < SN; i++) lens[i] = 0;
        for (int i = 0; i < 40; i++) lens[(i * 37 + 11) % SN] = (i < 8) ? 4 : (i < 24) ? 6 : 7;
        code = 0;
        for (int l = 1; l <= ML; l++) begin
            for (int j = 0; j < SN; j++)
                if (lens[j] == l) begin
                    codes[j] = code;
                    code++;
                end
            code = code << 1;
        end
        for (int j = 0; j < SN; j++)
            if (lens[j] != 0) exp_beat(j, lens[j], codes[j]);
        rand_rdy = 1'b1;
        start_job;
        for (int i = 0; i < 40; i++) begin
            s = (i * 37 + 11) % SN;
            load(s, lens[s], i == 39);
        end
        finish_job(0);
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        tick;

        // Scenario 6: reset mid-ASSIGN with a beat stalled, then rerun scenario 1
        out_ready = 1'b0;
        start_job;
        load(100, 1, 0);
        load(101, 1, 1);
        n = 0;
        while (!out_valid && n < 400) begin
            tick;
            n++;
        end
        chk("abort_valid_seen", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        tick;
        scen1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
